// File: rtl/hsci_phy_pkg.sv
// State encodings and per-state output decode shared by the HSCI PHY reset sequencer.
// Latency: n/a (declarations only); backpressure: n/a.
package hsci_phy_pkg;

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_BSC_RST   = 3'd2;
  localparam logic [2:0] ST_WAIT_DLY  = 3'd3;
  localparam logic [2:0] ST_WAIT_VTC  = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;
  localparam logic [2:0] ST_ERROR     = 3'd6;

  typedef enum logic [2:0] {
    S_PLL_RST   = ST_PLL_RST,
    S_WAIT_LOCK = ST_WAIT_LOCK,
    S_BSC_RST   = ST_BSC_RST,
    S_WAIT_DLY  = ST_WAIT_DLY,
    S_WAIT_VTC  = ST_WAIT_VTC,
    S_DONE      = ST_DONE,
    S_ERROR     = ST_ERROR
  } state_e;

  typedef struct packed {
    logic pll_rst;
    logic bsc_rst;
    logic en_vtc;
    logic done;
    logic err;
  } ctl_t;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Moore decode; evaluated on the next state so the output flops line up with the state flop.
  function automatic ctl_t state_ctl(state_e s);
    ctl_t c;
    c = '0;
    case (s)
      S_PLL_RST:   begin c.pll_rst = 1'b1; c.bsc_rst = 1'b1; end
      S_WAIT_LOCK: c.bsc_rst = 1'b1;
      S_BSC_RST:   c.bsc_rst = 1'b1;
      S_WAIT_VTC:  c.en_vtc = 1'b1;
      S_DONE:      begin c.en_vtc = 1'b1; c.done = 1'b1; end
      S_ERROR:     begin c.pll_rst = 1'b1; c.bsc_rst = 1'b1; c.err = 1'b1; end
      default:     c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hsci_sync2.sv
// 1-bit two-flop synchronizer into the sequencer clock domain, cleared by synchronous reset.
// Latency: 2 cycles; backpressure: none.
module hsci_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hsci_phy_rst_seq.sv
// HSCI PHY bring-up: PLL reset, lock wait, bitslice-control reset, DLY/VTC ready waits, retry on timeout.
// Latency: async inputs 2-cycle sync + 1 state cycle; backpressure: none (level-driven, seq_rst_req overrides).
module hsci_phy_rst_seq
  import hsci_phy_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 64,
  parameter int BSC_RST_CYCLES = 32,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int MAX_RETRY      = 3
) (
  input  logic       axi_clk,
  input  logic       axi_rst,
  input  logic       seq_rst_req,
  input  logic       pll_locked,
  input  logic       dly_rdy_tx,
  input  logic       dly_rdy_rx,
  input  logic       vtc_rdy_tx,
  input  logic       vtc_rdy_rx,
  output logic       pll_rst,
  output logic       bsc_rst,
  output logic       en_vtc,
  output logic       rst_seq_done,
  output logic       seq_err,
  output logic [2:0] seq_state,
  output logic [1:0] retry_cnt
);

  // One shared down-counter serves the fixed-length reset phases and the WAIT_* timeouts.
  localparam int CNT_W = $clog2(max3(TIMEOUT_CYCLES, PLL_RST_CYCLES, BSC_RST_CYCLES) + 1);
  localparam logic [CNT_W-1:0] PLL_LOAD  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] BSC_LOAD  = CNT_W'(BSC_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIM = 2'(MAX_RETRY);

  logic lock_s, dly_tx_s, dly_rx_s, vtc_tx_s, vtc_rx_s;

  hsci_sync2 u_sync_lock   (.clk(axi_clk), .rst(axi_rst), .d(pll_locked), .q(lock_s));
  hsci_sync2 u_sync_dly_tx (.clk(axi_clk), .rst(axi_rst), .d(dly_rdy_tx), .q(dly_tx_s));
  hsci_sync2 u_sync_dly_rx (.clk(axi_clk), .rst(axi_rst), .d(dly_rdy_rx), .q(dly_rx_s));
  hsci_sync2 u_sync_vtc_tx (.clk(axi_clk), .rst(axi_rst), .d(vtc_rdy_tx), .q(vtc_tx_s));
  hsci_sync2 u_sync_vtc_rx (.clk(axi_clk), .rst(axi_rst), .d(vtc_rdy_rx), .q(vtc_rx_s));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  ctl_t             ctl_q;
  logic             cnt_zero;
  logic             timeout;

  assign cnt_zero = (cnt_q == '0);

  function automatic logic [CNT_W-1:0] load_for(state_e s);
    case (s)
      S_PLL_RST: return PLL_LOAD;
      S_BSC_RST: return BSC_LOAD;
      default:   return TO_LOAD;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    timeout = 1'b0;
    case (state_q)
      S_PLL_RST:   if (cnt_zero) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: if (lock_s) state_d = S_BSC_RST;
                   else timeout = cnt_zero;
      S_BSC_RST:   if (!lock_s) state_d = S_PLL_RST;
                   else if (cnt_zero) state_d = S_WAIT_DLY;
      S_WAIT_DLY:  if (!lock_s) state_d = S_PLL_RST;
                   else if (dly_tx_s && dly_rx_s) state_d = S_WAIT_VTC;
                   else timeout = cnt_zero;
      S_WAIT_VTC:  if (!lock_s) state_d = S_PLL_RST;
                   else if (vtc_tx_s && vtc_rx_s) state_d = S_DONE;
                   else timeout = cnt_zero;
      S_DONE:      if (!lock_s) state_d = S_PLL_RST;
      S_ERROR:     state_d = S_ERROR;
      default:     state_d = S_ERROR;
    endcase

    // Lock loss already claimed the transition above, so it wins over an expiring timer.
    if (timeout) begin
      if (retry_q == RETRY_LIM) begin
        state_d = S_ERROR;
      end else begin
        state_d = S_PLL_RST;
        retry_d = retry_q + 2'd1;
      end
    end

    if (seq_rst_req) begin
      state_d = S_PLL_RST;
      retry_d = '0;
    end

    // Held request keeps reloading, so the PLL reset window only starts counting on release.
    if (seq_rst_req || (state_d != state_q)) cnt_d = load_for(state_d);
    else if (!cnt_zero)                      cnt_d = cnt_q - CNT_W'(1);
    else                                     cnt_d = cnt_q;
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state_q <= S_PLL_RST;
      cnt_q   <= PLL_LOAD;
      retry_q <= '0;
      ctl_q   <= state_ctl(S_PLL_RST);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      ctl_q   <= state_ctl(state_d);
    end
  end

  assign pll_rst      = ctl_q.pll_rst;
  assign bsc_rst      = ctl_q.bsc_rst;
  assign en_vtc       = ctl_q.en_vtc;
  assign rst_seq_done = ctl_q.done;
  assign seq_err      = ctl_q.err;
  assign seq_state    = state_q;
  assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_hsci_phy_rst_seq.sv
// Directed bench for hsci_phy_rst_seq with randomized event timing; expected state is a timeline
// computed from phase lengths (2-cycle sync + 1 register cycle per async event).
module tb_hsci_phy_rst_seq;

  localparam int PLL = 8;
  localparam int BSC = 4;
  localparam int TO  = 100;
  localparam int MR  = 3;
  localparam int P   = PLL + TO;

  logic       axi_clk = 1'b0;
  logic       axi_rst, seq_rst_req, pll_locked;
  logic       dly_rdy_tx, dly_rdy_rx, vtc_rdy_tx, vtc_rdy_rx;
  logic       pll_rst, bsc_rst, en_vtc, rst_seq_done, seq_err;
  logic [2:0] seq_state;
  logic [1:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  always #5 axi_clk = ~axi_clk;

  hsci_phy_rst_seq #(
    .PLL_RST_CYCLES(PLL),
    .BSC_RST_CYCLES(BSC),
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY     (MR)
  ) dut (
    .axi_clk     (axi_clk),
    .axi_rst     (axi_rst),
    .seq_rst_req (seq_rst_req),
    .pll_locked  (pll_locked),
    .dly_rdy_tx  (dly_rdy_tx),
    .dly_rdy_rx  (dly_rdy_rx),
    .vtc_rdy_tx  (vtc_rdy_tx),
    .vtc_rdy_rx  (vtc_rdy_rx),
    .pll_rst     (pll_rst),
    .bsc_rst     (bsc_rst),
    .en_vtc      (en_vtc),
    .rst_seq_done(rst_seq_done),
    .seq_err     (seq_err),
    .seq_state   (seq_state),
    .retry_cnt   (retry_cnt)
  );

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at t=%0t: observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  // Output table per state: 0 PLL_RST,1 WAIT_LOCK,2 BSC_RST,3 WAIT_DLY,4 WAIT_VTC,5 DONE,6 ERROR.
  task automatic chk_outs(input string tag, input int st, input int rc);
    chk({tag, ".state"},    8'(seq_state),    8'(st));
    chk({tag, ".pll_rst"},  8'(pll_rst),      8'(st == 0 || st == 6));
    chk({tag, ".bsc_rst"},  8'(bsc_rst),      8'(st <= 2 || st == 6));
    chk({tag, ".en_vtc"},   8'(en_vtc),       8'(st == 4 || st == 5));
    chk({tag, ".done"},     8'(rst_seq_done), 8'(st == 5));
    chk({tag, ".seq_err"},  8'(seq_err),      8'(st == 6));
    chk({tag, ".retry"},    8'(retry_cnt),    8'(rc));
  endtask

  initial begin
    int lk, dt, dtx, vt, vrx, st, dw, bd, xe;
    axi_rst = 1'b1; seq_rst_req = 1'b0; pll_locked = 1'b0;
    dly_rdy_tx = 1'b0; dly_rdy_rx = 1'b0; vtc_rdy_tx = 1'b0; vtc_rdy_rx = 1'b0;
    repeat (3) tick();
    chk_outs("reset", 0, 0);
    axi_rst = 1'b0;

    // Nominal bring-up; k counts cycles since reset release.
    lk  = 14 + $urandom_range(0, 12);
    dt  = lk + BSC + 4 + $urandom_range(0, 6);
    dtx = dt - $urandom_range(0, 4);
    vt  = dt + 4 + $urandom_range(0, 6);
    vrx = vt - $urandom_range(0, 3);
    for (int k = 0; k <= vt + 5; k++) begin
      st = (k < PLL) ? 0 : (k < lk + 3) ? 1 : (k < lk + 3 + BSC) ? 2 :
           (k < dt + 3) ? 3 : (k < vt + 3) ? 4 : 5;
      chk_outs("nominal", st, 0);
      if (k == lk)  pll_locked = 1'b1;
      if (k == dtx) dly_rdy_tx = 1'b1;
      if (k == dt)  dly_rdy_rx = 1'b1;
      if (k == vt)  vtc_rdy_tx = 1'b1;
      if (k == vrx) vtc_rdy_rx = 1'b1;
      tick();
    end

    // One-cycle lock glitch in DONE restarts without a retry, then re-reaches DONE.
    dw = $urandom_range(0, 4);
    for (int i = 0; i < dw; i++) begin
      chk_outs("done_dwell", 5, 0);
      tick();
    end
    for (int r = 0; r <= 20; r++) begin
      st = (r < 3) ? 5 : (r < 3 + PLL) ? 0 : (r < 4 + PLL) ? 1 :
           (r < 4 + PLL + BSC) ? 2 : (r < 5 + PLL + BSC) ? 3 : (r < 6 + PLL + BSC) ? 4 : 5;
      chk_outs("lock_glitch", st, 0);
      pll_locked = (r != 0);
      tick();
    end

    // Restart via one-cycle request with ready inputs dropped; park in WAIT_DLY.
    dw = $urandom_range(0, 5);
    for (int c = 0; c <= 2 + PLL + BSC + dw; c++) begin
      st = (c < 1) ? 5 : (c < 1 + PLL) ? 0 : (c < 2 + PLL) ? 1 : (c < 2 + PLL + BSC) ? 2 : 3;
      chk_outs("req_pulse", st, 0);
      if (c == 0) begin
        dly_rdy_tx = 1'b0; dly_rdy_rx = 1'b0; vtc_rdy_tx = 1'b0; vtc_rdy_rx = 1'b0;
        seq_rst_req = 1'b1;
      end
      if (c == 1) seq_rst_req = 1'b0;
      tick();
    end

    // Request held 50 cycles in WAIT_DLY, then only dly_rdy_tx: times out into retry 1.
    bd = 51 + PLL + BSC + TO;
    for (int q = 0; q < bd; q++) begin
      st = (q < 1) ? 3 : (q < 50 + PLL) ? 0 : (q < 51 + PLL) ? 1 : (q < 51 + PLL + BSC) ? 2 : 3;
      chk_outs("req_hold", st, 0);
      if (q == 0) begin
        seq_rst_req = 1'b1;
        dly_rdy_tx  = 1'b1;
      end
      if (q == 50) seq_rst_req = 1'b0;
      tick();
    end

    // Lock loss landing on the same edge as timeout expiry: retry count must stay at 1.
    xe = PLL + 1 + BSC + TO;
    for (int e = 0; e <= xe; e++) begin
      st = (e < PLL) ? 0 : (e < PLL + 1) ? 1 : (e < PLL + 1 + BSC) ? 2 : (e < xe) ? 3 : 0;
      chk_outs("lock_vs_timeout", st, 1);
      if (e == xe - 3) pll_locked = 1'b0;
      tick();
    end

    // Lock never returns: four timed-out attempts, then sticky ERROR.
    seq_rst_req = 1'b1;
    tick();
    seq_rst_req = 1'b0;
    dw = $urandom_range(2, 8);
    for (int f = 0; f <= 4 * P + dw; f++) begin
      if (f < 4 * P) chk_outs("no_lock", ((f % P) < PLL) ? 0 : 1, f / P);
      else           chk_outs("error_hold", 6, MR);
      tick();
    end

    // Request clears ERROR and starts a fresh attempt.
    seq_rst_req = 1'b1;
    tick();
    seq_rst_req = 1'b0;
    for (int g = 0; g <= PLL + 3; g++) begin
      chk_outs("err_clear", (g < PLL) ? 0 : 1, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
